lstm_cell_feeder: RTL

Sequencer that drives one LSTM cell from the input side and closes its recurrent loop. It accepts X_SIZE input samples per time step over a valid/ready stream and issues weight-ROM addresses. It streams the samples, followed by the stored previous h, into the cell's serial x/in_valid port, then captures the cell's c_o/h_o back into state registers. Each step's h is presented downstream, and state is cleared after SEQ_LEN steps.

---
 rtl/lstm_cell_feeder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/lstm_cell_feeder.sv
// Feeds X_SIZE streamed samples plus the recurrent h into a serial LSTM cell and captures c/h back.
// Optional cell-response watchdog is enabled by defining LSTM_FEEDER_TIMEOUT_EN.
module lstm_cell_feeder #(
    parameter int X_SIZE  = 25,
    parameter int D_WL    = 16,
    parameter int SEQ_LEN = 8,
    parameter int AW      = 5,
    parameter int TIMEOUT = 256
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_s_valid,
    output logic            o_s_ready,
    input  logic [D_WL-1:0] i_s_data,
    output logic [AW-1:0]   o_rom_addr,
    output logic [D_WL-1:0] o_cell_x,
    output logic            o_cell_in_valid,
    output logic [D_WL-1:0] o_cell_pre_c,
    input  logic            i_cell_c_o_valid,
    input  logic [D_WL-1:0] i_cell_c_o,
    input  logic            i_cell_h_o_valid,
    input  logic [D_WL-1:0] i_cell_h_o,
    output logic            o_m_valid,
    output logic [D_WL-1:0] o_m_data,
    output logic            o_m_last,
    input  logic            i_m_ready,
    output logic            o_busy,
    output logic            o_err
);

    localparam int SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [AW-1:0] LAST_CNT  = AW'(X_SIZE - 1);
    localparam logic [AW-1:0] H_ADDR    = AW'(X_SIZE);
    localparam logic [SW-1:0] LAST_STEP = SW'(SEQ_LEN - 1);

    if ((2 ** AW) <= X_SIZE) begin : g_aw_check
        $error("lstm_cell_feeder: AW too narrow to address the h weight row");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("lstm_cell_feeder: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED_X,
        ST_FEED_H,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_cnt;
    logic [SW-1:0]   r_step;
    logic [D_WL-1:0] r_h;
    logic [D_WL-1:0] r_c;
    logic [D_WL-1:0] r_cell_x;
    logic            r_cell_in_valid;
    logic            r_m_valid;
    logic [D_WL-1:0] r_m_data;
    logic            r_m_last;
    logic [AW-1:0]   w_rom_addr;

    logic w_accept;
    logic w_last_x;
    logic w_last_step;
    logic w_c_cap;
    logic w_h_cap;
    logic w_out_done;
    logic w_timeout;

    assign w_accept    = (r_state == ST_FEED_X) && i_s_valid;
    assign w_last_x    = (r_cnt == LAST_CNT);
    assign w_last_step = (r_step == LAST_STEP);
    assign w_c_cap     = (r_state == ST_WAIT) && i_cell_c_o_valid;
    assign w_h_cap     = (r_state == ST_WAIT) && i_cell_h_o_valid;
    assign w_out_done  = (r_state == ST_OUT) && i_m_ready;

`ifdef LSTM_FEEDER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] r_wd;
    logic           r_err;

    // Counts WAIT cycles; the cell gets TIMEOUT cycles to deliver h before the step is abandoned.
    assign w_timeout = (r_state == ST_WAIT) && !i_cell_h_o_valid && (r_wd == WD_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ST_FEED_H) begin
                r_wd <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FEED_X;
            end
            ST_FEED_X: begin
                if (w_accept && w_last_x) begin
                    w_next_state = ST_FEED_H;
                end
            end
            ST_FEED_H: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_cell_h_o_valid) begin
                    w_next_state = ST_OUT;
                end else if (w_timeout) begin
                    w_next_state = ST_FEED_X;
                end
            end
            ST_OUT: begin
                if (i_m_ready) begin
                    w_next_state = ST_FEED_X;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Sequence datapath: element register toward the cell, recurrent state and the step output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt           <= '0;
            r_step          <= '0;
            r_h             <= '0;
            r_c             <= '0;
            r_cell_x        <= '0;
            r_cell_in_valid <= 1'b0;
            r_m_valid       <= 1'b0;
            r_m_data        <= '0;
            r_m_last        <= 1'b0;
        end else begin
            case (r_state)
                ST_FEED_X: begin
                    if (w_accept) begin
                        r_cell_x        <= i_s_data;
                        r_cell_in_valid <= 1'b1;
                        r_cnt           <= w_last_x ? '0 : r_cnt + 1'b1;
                    end else begin
                        r_cell_in_valid <= 1'b0;
                    end
                end
                ST_FEED_H: begin
                    r_cell_x        <= r_h;
                    r_cell_in_valid <= 1'b1;
                end
                ST_WAIT: begin
                    r_cell_in_valid <= 1'b0;
                    if (w_c_cap) begin
                        r_c <= i_cell_c_o;
                    end
                    if (w_h_cap) begin
                        r_h       <= i_cell_h_o;
                        r_m_data  <= i_cell_h_o;
                        r_m_valid <= 1'b1;
                        r_m_last  <= w_last_step;
                    end else if (w_timeout) begin
                        r_h    <= '0;
                        r_c    <= '0;
                        r_step <= '0;
                        r_cnt  <= '0;
                    end
                end
                ST_OUT: begin
                    if (w_out_done) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (w_last_step) begin
                            r_h    <= '0;
                            r_c    <= '0;
                            r_step <= '0;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_rom_addr = '0;
        case (r_state)
            ST_FEED_X: w_rom_addr = r_cnt;
            ST_FEED_H: w_rom_addr = H_ADDR;
            default:   w_rom_addr = '0;
        endcase
    end

    assign o_rom_addr      = w_rom_addr;
    assign o_s_ready       = (r_state == ST_FEED_X);
    assign o_busy          = (r_state != ST_FEED_X);
    assign o_cell_x        = r_cell_x;
    assign o_cell_in_valid = r_cell_in_valid;
    assign o_cell_pre_c    = r_c;
    assign o_m_valid       = r_m_valid;
    assign o_m_data        = r_m_data;
    assign o_m_last        = r_m_last;

endmodule
